// File: rtl/revaluate_instance_cu.sv
// Per-instance round re-evaluation sweeper: Read/Exec pair per slice, every slice of every round, then a Done pulse.
// Busy for 2*ROUNDS*SLICES+1 cycles after start; ready is low throughout and start is ignored while busy.
module revaluate_instance_cu #(
   parameter int ROUNDS  = 24,
   parameter int SLICES  = 64,
   parameter int ADDR_W  = 6,
   parameter int ROUND_W = 5
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start_instance,
   output logic               mem_rd_en,
   output logic               mem_wr_en,
   output logic               compute_en,
   output logic [ADDR_W-1:0]  mem_addr,
   output logic [ROUND_W-1:0] round_idx,
   output logic               last_round,
   output logic               done,
   output logic               ready
);

   typedef enum logic [1:0] {IDLE, READ, EXEC, DONE} state_t;

   localparam logic [ADDR_W-1:0]  SLICE_LAST = ADDR_W'(SLICES - 1);
   localparam logic [ROUND_W-1:0] ROUND_LAST = ROUND_W'(ROUNDS - 1);

   state_t             state, state_nxt;
   logic [ADDR_W-1:0]  slice, slice_nxt;
   logic [ROUND_W-1:0] round, round_nxt;

   always_ff @(posedge clk) begin
      if (!rst) begin
         state <= IDLE;
         slice <= '0;
         round <= '0;
      end else begin
         state <= state_nxt;
         slice <= slice_nxt;
         round <= round_nxt;
      end
   end

   always_comb begin
      state_nxt  = state;
      slice_nxt  = slice;
      round_nxt  = round;
      mem_rd_en  = 1'b0;
      mem_wr_en  = 1'b0;
      compute_en = 1'b0;
      mem_addr   = '0;
      round_idx  = '0;
      last_round = 1'b0;
      done       = 1'b0;
      ready      = 1'b0;
      case (state)
         IDLE: begin
            ready = 1'b1;
            if (start_instance) begin
               state_nxt = READ;
               slice_nxt = '0;
               round_nxt = '0;
            end
         end
         READ: begin
            mem_rd_en  = 1'b1;
            mem_addr   = slice;
            round_idx  = round;
            last_round = (round == ROUND_LAST);
            state_nxt  = EXEC;
         end
         EXEC: begin
            // Write-back targets the slice read in the previous cycle
            compute_en = 1'b1;
            mem_wr_en  = 1'b1;
            mem_addr   = slice;
            round_idx  = round;
            last_round = (round == ROUND_LAST);
            if (slice != SLICE_LAST) begin
               slice_nxt = slice + 1'b1;
               state_nxt = READ;
            end else if (round != ROUND_LAST) begin
               slice_nxt = '0;
               round_nxt = round + 1'b1;
               state_nxt = READ;
            end else begin
               state_nxt = DONE;
            end
         end
         DONE: begin
            done      = 1'b1;
            state_nxt = IDLE;
            slice_nxt = '0;
            round_nxt = '0;
         end
         default: state_nxt = IDLE;
      endcase
   end

   rd_wr_exclusive: assert property (@(posedge clk) !(mem_rd_en && mem_wr_en));

endmodule

// File: tb/tb_revaluate_instance_cu.sv
// Randomized bench for revaluate_instance_cu: a small (2x4) and a default (24x64) instance vs. a phase-based model.
module tb_revaluate_instance_cu;

   typedef struct packed {
      logic       ready, done, rd, wr, ce, last;
      logic [7:0] addr;
      logic [7:0] rnd;
   } obs_t;

   logic       clk = 1'b0;
   logic       s_rst = 1'b0, s_start = 1'b0, b_rst = 1'b0, b_start = 1'b0;
   logic       s_rd, s_wr, s_ce, s_last, s_done, s_ready;
   logic [1:0] s_addr;
   logic [0:0] s_round;
   logic       b_rd, b_wr, b_ce, b_last, b_done, b_ready;
   logic [5:0] b_addr;
   logic [4:0] b_round;
   int n_checks = 0, n_pass = 0;

   always #5 clk = ~clk;

   revaluate_instance_cu #(.ROUNDS(2), .SLICES(4), .ADDR_W(2), .ROUND_W(1)) u_small (
      .clk(clk), .rst(s_rst), .start_instance(s_start), .mem_rd_en(s_rd), .mem_wr_en(s_wr),
      .compute_en(s_ce), .mem_addr(s_addr), .round_idx(s_round), .last_round(s_last),
      .done(s_done), .ready(s_ready));

   revaluate_instance_cu u_big (
      .clk(clk), .rst(b_rst), .start_instance(b_start), .mem_rd_en(b_rd), .mem_wr_en(b_wr),
      .compute_en(b_ce), .mem_addr(b_addr), .round_idx(b_round), .last_round(b_last),
      .done(b_done), .ready(b_ready));

   // Expected outputs p cycles after start was sampled (p=0 or past the sweep: idle).
   function automatic obs_t model(int R, int S, int p);
      obs_t o = '0;
      int k, pair;
      if (p >= 1 && p <= 2*R*S) begin
         k      = p - 1;
         pair   = k / 2;
         o.rd   = (k % 2 == 0);
         o.wr   = (k % 2 == 1);
         o.ce   = (k % 2 == 1);
         o.addr = 8'(pair % S);
         o.rnd  = 8'(pair / S);
         o.last = (pair / S == R - 1);
      end else if (p == 2*R*S + 1) begin
         o.done = 1'b1;
      end else begin
         o.ready = 1'b1;
      end
      return o;
   endfunction

   function automatic obs_t obs_small();
      return {s_ready, s_done, s_rd, s_wr, s_ce, s_last, 8'(s_addr), 8'(s_round)};
   endfunction

   function automatic obs_t obs_big();
      return {b_ready, b_done, b_rd, b_wr, b_ce, b_last, 8'(b_addr), 8'(b_round)};
   endfunction

   task automatic pulse_small();
      s_start = 1'b1;
      @(posedge clk); #1;
      s_start = 1'b0;
   endtask

   task automatic test_reset();
      obs_t o, e;
      s_rst = 1'b0; b_rst = 1'b0; s_start = 1'b1; b_start = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      s_start = 1'b0; b_start = 1'b0;
      @(negedge clk);
      e = model(2, 4, 0);
      o = obs_small();
      n_checks++;
      if (o !== e) $display("FAIL reset_small got=%h exp=%h", o, e); else n_pass++;
      o = obs_big();
      n_checks++;
      if (o !== e) $display("FAIL reset_big got=%h exp=%h", o, e); else n_pass++;
      @(posedge clk); #1;
      s_rst = 1'b1; b_rst = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_basic_sweep();
      obs_t o, e;
      int q_rd[$], q_wr[$], exp_seq[$];
      int busy = 0, dones = 0;
      pulse_small();
      for (int p = 1; p <= 20; p++) begin
         @(negedge clk);
         o = obs_small();
         e = model(2, 4, p);
         n_checks++;
         if (o !== e) $display("FAIL sweep p=%0d got=%h exp=%h", p, o, e); else n_pass++;
         if (!s_ready) busy++;
         if (s_done) dones++;
         if (s_rd) q_rd.push_back(int'(s_addr));
         if (s_wr) q_wr.push_back(int'(s_addr));
         @(posedge clk); #1;
      end
      for (int r = 0; r < 2; r++)
         for (int s = 0; s < 4; s++) exp_seq.push_back(s);
      n_checks++;
      if (busy != 17) $display("FAIL busy_len got=%0d exp=17", busy); else n_pass++;
      n_checks++;
      if (dones != 1) $display("FAIL done_count got=%0d exp=1", dones); else n_pass++;
      n_checks++;
      if (q_rd != exp_seq) $display("FAIL rd_seq got=%p exp=%p", q_rd, exp_seq); else n_pass++;
      n_checks++;
      if (q_wr != exp_seq) $display("FAIL wr_seq got=%p exp=%p", q_wr, exp_seq); else n_pass++;
   endtask

   task automatic test_ignored_start();
      obs_t o, e;
      int busy;
      for (int it = 0; it < 4; it++) begin
         busy = 0;
         pulse_small();
         for (int p = 1; p <= 19; p++) begin
            // Spurious starts only while busy (phases 1..17); cycle 5 and Done always hit
            s_start = (p <= 17) && (p == 5 || p == 17 || ($urandom_range(0, 2) == 0));
            @(negedge clk);
            o = obs_small();
            e = model(2, 4, p);
            n_checks++;
            if (o !== e) $display("FAIL ignored_start it=%0d p=%0d got=%h exp=%h", it, p, o, e);
            else n_pass++;
            if (!s_ready) busy++;
            @(posedge clk); #1;
         end
         s_start = 1'b0;
         n_checks++;
         if (busy != 17) $display("FAIL ignored_busy it=%0d got=%0d exp=17", it, busy); else n_pass++;
      end
   endtask

   task automatic test_reset_mid();
      obs_t o, e;
      int cut;
      for (int it = 0; it < 4; it++) begin
         cut = (it == 0) ? 9 : int'($urandom_range(2, 16));
         pulse_small();
         for (int p = 1; p < cut; p++) begin
            @(posedge clk); #1;
         end
         s_rst = 1'b0;
         s_start = 1'($urandom_range(0, 1));
         @(negedge clk);
         o = obs_small();
         e = model(2, 4, cut);
         n_checks++;
         if (o !== e) $display("FAIL pre_rst it=%0d p=%0d got=%h exp=%h", it, cut, o, e); else n_pass++;
         @(posedge clk); #1;
         s_rst = 1'b1; s_start = 1'b0;
         @(negedge clk);
         o = obs_small();
         e = model(2, 4, 0);
         n_checks++;
         if (o !== e) $display("FAIL post_rst it=%0d cut=%0d got=%h exp=%h", it, cut, o, e); else n_pass++;
         @(posedge clk); #1;
         pulse_small();
         for (int p = 1; p <= 19; p++) begin
            @(negedge clk);
            o = obs_small();
            e = model(2, 4, p);
            n_checks++;
            if (o !== e) $display("FAIL restart it=%0d p=%0d got=%h exp=%h", it, p, o, e); else n_pass++;
            @(posedge clk); #1;
         end
      end
   endtask

   task automatic test_idle_hold();
      obs_t o, e;
      s_rst = 1'b0;
      @(posedge clk); #1;
      s_rst = 1'b1;
      e = model(2, 4, 0);
      for (int c = 0; c < 100; c++) begin
         @(negedge clk);
         o = obs_small();
         n_checks++;
         if (o !== e) $display("FAIL idle_hold c=%0d got=%h exp=%h", c, o, e); else n_pass++;
         @(posedge clk); #1;
      end
   endtask

   task automatic test_defaults();
      obs_t o, e;
      int busy = 0, writes = 0, dones = 0;
      b_start = 1'b1;
      @(posedge clk); #1;
      for (int p = 1; p <= 3076; p++) begin
         b_start = (p <= 2);
         @(negedge clk);
         o = obs_big();
         e = model(24, 64, p);
         n_checks++;
         if (o !== e) $display("FAIL defaults p=%0d got=%h exp=%h", p, o, e); else n_pass++;
         if (!b_ready) busy++;
         if (b_wr) writes++;
         if (b_done) dones++;
         @(posedge clk); #1;
      end
      n_checks++;
      if (busy != 3073) $display("FAIL def_busy got=%0d exp=3073", busy); else n_pass++;
      n_checks++;
      if (writes != 1536) $display("FAIL def_writes got=%0d exp=1536", writes); else n_pass++;
      n_checks++;
      if (dones != 1) $display("FAIL def_done got=%0d exp=1", dones); else n_pass++;
   endtask

   initial begin
      test_reset();
      test_basic_sweep();
      test_ignored_start();
      test_reset_mid();
      test_idle_hold();
      test_defaults();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
